// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        NONE,
        BRANCH,
        RETURN
    } if_redirect_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; the head entry is read straight from the
// storage registers, so the output never depends on push_data in the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when a pop frees the slot.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/stage_if_prefetch.sv
// Instruction-fetch stage: sequential requests to a pipelined instruction memory,
// returned {pc, inst} pairs queued for decode, redirects flush queued and in-flight work.
module stage_if_prefetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FETCH_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pc_stall,
    input  logic        if_flush,
    input  logic        br_ctrl,
    input  logic [31:0] br_addr,
    input  logic        ret_ctrl,
    input  logic [31:0] ret_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);

    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int DCW = $clog2(FETCH_DEPTH + 1);

    logic           run;
    logic [31:0]    fetch_pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  outstanding_next;
    logic [CW-1:0]  drop;
    logic [DCW-1:0] data_count;
    logic [31:0]    tag_head;
    if_redirect_t   redir_kind;
    logic           redir;
    logic [31:0]    redir_target;
    logic           credit_ok;
    logic           grant;
    logic           rsp_keep;
    logic           pop_head;
    fetch_entry_t   push_entry;
    fetch_entry_t   head_entry;

    always_comb begin
        redir_kind   = NONE;
        redir_target = fetch_pc;
        if (br_ctrl) begin
            redir_kind = BRANCH;
        end else if (ret_ctrl) begin
            redir_kind = RETURN;
        end
        case (redir_kind)
            BRANCH:  redir_target = br_addr;
            RETURN:  redir_target = ret_pc;
            default: redir_target = fetch_pc;
        endcase
    end

    assign redir = (redir_kind != NONE);

    // Every granted request reserves a FIFO slot, so returned data always fits.
    assign credit_ok = (int'(outstanding) < MAX_OUTSTANDING) &&
                       (int'(data_count) + int'(outstanding) < FETCH_DEPTH);
    assign imem_req  = run && !redir && credit_ok;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid);
    assign rsp_keep         = imem_rvalid && (drop == '0) && !redir;
    assign pop_head         = !redir && if_valid && (!pc_stall || if_flush);
    assign push_entry       = '{pc: tag_head, inst: imem_rdata};

    // run holds off the first request for one cycle so imem_req is low out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            drop     <= '0;
        end else begin
            run <= 1'b1;
            if (redir) begin
                fetch_pc <= {redir_target[31:2], 2'b00};
                drop     <= outstanding_next;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rvalid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    // Tag-queue occupancy is the outstanding-request count; it is never cleared
    // so that discarded responses still retire their own tags in order.
    fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (32),
        .CW    (CW)
    ) u_tag_q (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (1'b0),
        .push      (grant),
        .push_data (fetch_pc),
        .pop       (imem_rvalid),
        .head      (tag_head),
        .count     (outstanding)
    );

    fetch_fifo #(
        .DEPTH (FETCH_DEPTH),
        .WIDTH ($bits(fetch_entry_t)),
        .CW    (DCW)
    ) u_data_q (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (redir),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop_head),
        .head      (head_entry),
        .count     (data_count)
    );

    assign if_valid = (data_count != '0);
    assign if_inst  = if_valid ? head_entry.inst : NOP;
    assign if_pc    = if_valid ? head_entry.pc : 32'h0000_0000;

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Bench for stage_if_prefetch: in-order memory responder with configurable latency,
// expected delivery stream derived from the redirect target and sequential +4 rule.
module tb_stage_if_prefetch;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAXO     = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pc_stall;
    logic        if_flush;
    logic        br_ctrl;
    logic [31:0] br_addr;
    logic        ret_ctrl;
    logic [31:0] ret_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    always #5 clk = ~clk;

    stage_if_prefetch #(
        .RESET_PC        (RESET_PC),
        .FETCH_DEPTH     (4),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pc_stall    (pc_stall),
        .if_flush    (if_flush),
        .br_ctrl     (br_ctrl),
        .br_addr     (br_addr),
        .ret_ctrl    (ret_ctrl),
        .ret_pc      (ret_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // memory model: granted addresses with the cycle their response may return
    logic [31:0] mq_addr[$];
    int          mq_ready[$];
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          gnt_max  = 0;
    int          gnt_wait = 0;

    // reference: next PC decode should see, next address fetch should issue
    logic [31:0] exp_pc;
    logic [31:0] exp_issue;

    // per-cycle observations, taken before the active edge
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_pc, o_inst, o_exp_pc, o_exp_issue;
    int          o_mq_size;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // One clock cycle: the caller has set stall/flush/redirect inputs already.
    task automatic cycle();
        logic [31:0] tgt;
        #1;
        imem_gnt = 1'b0;
        if (imem_req) begin
            if (gnt_wait == 0) imem_gnt = 1'b1;
            else gnt_wait--;
        end
        imem_rvalid = (mq_addr.size() != 0) && (mq_ready[0] <= cyc);
        imem_rdata  = imem_rvalid ? inst_of(mq_addr[0]) : $urandom();
        #1;
        o_req       = imem_req;
        o_addr      = imem_addr;
        o_valid     = if_valid;
        o_pc        = if_pc;
        o_inst      = if_inst;
        o_exp_pc    = exp_pc;
        o_exp_issue = exp_issue;
        o_mq_size   = mq_addr.size();
        if (imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_ready.pop_front());
        end
        if (imem_req && imem_gnt) begin
            mq_addr.push_back(imem_addr);
            mq_ready.push_back(cyc + $urandom_range(lat_min, lat_max));
            gnt_wait = $urandom_range(0, gnt_max);
        end
        if (br_ctrl || ret_ctrl) begin
            tgt       = br_ctrl ? br_addr : ret_pc;
            exp_pc    = tgt & ~32'd3;
            exp_issue = tgt & ~32'd3;
        end else begin
            if (o_valid && (!pc_stall || if_flush)) exp_pc = exp_pc + 32'd4;
            if (imem_req && imem_gnt) exp_issue = exp_issue + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        pc_stall    = 1'b0;
        if_flush    = 1'b0;
        br_ctrl     = 1'b0;
        ret_ctrl    = 1'b0;
        br_addr     = '0;
        ret_pc      = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        mq_addr.delete();
        mq_ready.delete();
        gnt_wait  = 0;
        exp_pc    = RESET_PC;
        exp_issue = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1; gnt_max = 0;
        do_reset();
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++;
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        n_checks++;
        if (if_inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h want %h", if_inst, NOP); end
        n_checks++;
        if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", if_pc); end
        n_checks++;
        if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
        rstn = 1'b1;
        cycle();
        n_checks++;
        if (o_req !== 1'b0) begin n_fail++; $display("FAIL release_req_c0: got %b want 0", o_req); end
    endtask

    task automatic test_sequential();
        cycle();
        n_checks++;
        if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
            n_fail++; $display("FAIL seq_first_req: got req=%b addr=%h want req=1 addr=%h", o_req, o_addr, RESET_PC);
        end
        cycle();
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL seq_c2_valid: got %b want 0", o_valid); end
        for (int k = 0; k < 8; k++) begin
            cycle();
            n_checks++;
            if (o_valid !== 1'b1 || o_pc !== RESET_PC + 32'(4 * k) || o_inst !== inst_of(RESET_PC + 32'(4 * k))) begin
                n_fail++;
                $display("FAIL seq_stream[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, o_valid, o_pc, o_inst,
                         RESET_PC + 32'(4 * k), inst_of(RESET_PC + 32'(4 * k)));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] first;
        first    = exp_pc;
        pc_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_checks++;
            if (o_valid !== 1'b1 || o_pc !== first || o_inst !== inst_of(first)) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h want pc=%h", i, o_valid, o_pc, o_inst, first);
            end
        end
        n_checks++;
        if (o_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_full: got %b want 0", o_req); end
        pc_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_checks++;
            if (o_valid !== 1'b1 || o_pc !== first + 32'(4 * i)) begin
                n_fail++; $display("FAIL stall_release[%0d]: got v=%b pc=%h want v=1 pc=%h", i, o_valid, o_pc, first + 32'(4 * i));
            end
        end
    endtask

    task automatic test_branch();
        int guard;
        lat_min = 2; lat_max = 2;
        guard = 0;
        while (mq_addr.size() != 2 && guard < 20) begin
            cycle();
            guard++;
        end
        n_checks++;
        if (mq_addr.size() != 2) begin n_fail++; $display("FAIL br_inflight: got %0d want 2", mq_addr.size()); end
        br_ctrl = 1'b1;
        br_addr = 32'h0000_0100;
        cycle();
        br_ctrl = 1'b0;
        n_checks++;
        if (o_req !== 1'b0) begin n_fail++; $display("FAIL br_req_on_redirect: got %b want 0", o_req); end
        cycle();
        n_checks++;
        if (o_req !== 1'b1 || o_addr !== 32'h100 || o_valid !== 1'b0) begin
            n_fail++; $display("FAIL br_target_req: got req=%b addr=%h v=%b want 1 100 0", o_req, o_addr, o_valid);
        end
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL br_discard[%0d]: got v=%b pc=%h want 0", i, o_valid, o_pc); end
        end
        cycle();
        n_checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_inst !== inst_of(32'h100)) begin
            n_fail++; $display("FAIL br_first: got v=%b pc=%h inst=%h want 1 100 %h", o_valid, o_pc, o_inst, inst_of(32'h100));
        end
    endtask

    task automatic test_dual_redirect();
        lat_min = 1; lat_max = 1;
        repeat (5) cycle();
        br_ctrl  = 1'b1;
        ret_ctrl = 1'b1;
        br_addr  = 32'h0000_0200;
        ret_pc   = 32'h0000_0300;
        cycle();
        br_ctrl  = 1'b0;
        ret_ctrl = 1'b0;
        cycle();
        n_checks++;
        if (o_req !== 1'b1 || o_addr !== 32'h200) begin
            n_fail++; $display("FAIL dual_req: got req=%b addr=%h want 1 200", o_req, o_addr);
        end
        cycle();
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL dual_gap: got v=%b want 0", o_valid); end
        cycle();
        n_checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h200) begin
            n_fail++; $display("FAIL dual_first: got v=%b pc=%h want 1 200", o_valid, o_pc);
        end
    endtask

    task automatic test_flush();
        int guard;
        br_ctrl  = 1'b1;
        br_addr  = 32'h0000_0010;
        pc_stall = 1'b1;
        cycle();
        br_ctrl = 1'b0;
        guard   = 0;
        do begin
            cycle();
            guard++;
        end while (!o_valid && guard < 10);
        n_checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h10) begin
            n_fail++; $display("FAIL flush_head: got v=%b pc=%h want 1 10", o_valid, o_pc);
        end
        if_flush = 1'b1;
        cycle();
        if_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (o_valid !== 1'b1 || o_pc !== 32'h14 || o_inst !== inst_of(32'h14)) begin
                n_fail++; $display("FAIL flush_next[%0d]: got v=%b pc=%h inst=%h want 1 14", i, o_valid, o_pc, o_inst);
            end
        end
        pc_stall = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_reset_midop();
        rstn = 1'b0;
        #1;
        n_checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0 || if_inst !== NOP || if_pc !== 32'h0) begin
            n_fail++; $display("FAIL midop_reset: got v=%b req=%b inst=%h pc=%h want 0 0 %h 0", if_valid, imem_req, if_inst, if_pc, NOP);
        end
        do_reset();
        rstn = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
            n_fail++; $display("FAIL midop_restart: got req=%b addr=%h want 1 %h", o_req, o_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        int r;
        int delivered;
        delivered = 0;
        lat_min = 1; lat_max = 6; gnt_max = 5;
        for (int n = 0; n < 3000; n++) begin
            pc_stall = ($urandom_range(0, 9) < 3);
            if_flush = ($urandom_range(0, 19) == 0);
            r        = $urandom_range(0, 39);
            br_ctrl  = (r == 0) || (r == 2);
            ret_ctrl = (r == 1) || (r == 2);
            br_addr  = ($urandom_range(0, 3) == 0) ? 32'hffff_fff8 : ($urandom() & ~32'd3);
            ret_pc   = $urandom() & ~32'd3;
            cycle();
            if (o_valid) begin
                n_checks++;
                if (o_pc !== o_exp_pc || o_inst !== inst_of(o_exp_pc)) begin
                    n_fail++; $display("FAIL rnd_head c%0d: got pc=%h inst=%h want pc=%h inst=%h", cyc, o_pc, o_inst, o_exp_pc, inst_of(o_exp_pc));
                end
                if (!br_ctrl && !ret_ctrl && (!pc_stall || if_flush)) delivered++;
            end else begin
                n_checks++;
                if (o_inst !== NOP || o_pc !== 32'h0) begin
                    n_fail++; $display("FAIL rnd_idle c%0d: got pc=%h inst=%h want 0 %h", cyc, o_pc, o_inst, NOP);
                end
            end
            if (o_req) begin
                n_checks++;
                if (o_addr !== o_exp_issue || o_mq_size >= MAXO) begin
                    n_fail++; $display("FAIL rnd_issue c%0d: got addr=%h inflight=%0d want addr=%h inflight<%0d", cyc, o_addr, o_mq_size, o_exp_issue, MAXO);
                end
            end
        end
        br_ctrl  = 1'b0;
        ret_ctrl = 1'b0;
        pc_stall = 1'b0;
        if_flush = 1'b0;
        n_checks++;
        if (delivered < 200) begin n_fail++; $display("FAIL rnd_progress: got %0d delivered want >=200", delivered); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_dual_redirect();
        test_flush();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stage_if_prefetch.md
# stage_if_prefetch

Parametrised instruction-fetch stage with a decoupled prefetch queue. It issues sequential fetch requests to a handshaked instruction-memory port and buffers returned {pc, inst} pairs in a FETCH_DEPTH-entry FIFO. It presents one instruction per cycle to decode under `pc_stall` back-pressure. Branch and return redirects discard queued and in-flight fetches. It replaces the single-cycle PC/ROM fetch in the core front end and supports multi-cycle, pipelined instruction memories.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FETCH_DEPTH`, 4, prefetch FIFO entries; power of two, ≥2
- `MAX_OUTSTANDING`, 2, maximum granted-but-unreturned memory requests; 1..FETCH_DEPTH
- `clk`  in  1  core clock; single clock domain
- `rstn`  in  1  asynchronous, active-low reset
- `pc_stall`  in  1  decode not accepting; head entry held
- `if_flush`  in  1  discard current head entry (one bubble); no PC change
- `br_ctrl`  in  1  branch redirect
- `br_addr`  in  32  branch target
- `ret_ctrl`  in  1  return redirect
- `ret_pc`  in  32  return target
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, word aligned
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid; responses return in request order
- `imem_rdata`  in  32  response instruction
- `if_valid`  out  1  head entry valid
- `if_inst`  out  32  head instruction; 32'h0000_0013 (NOP) when !if_valid
- `if_pc`  out  32  head PC; 0 when !if_valid

## Operation
- Reset values: `fetch_pc` = RESET_PC, FIFO empty, outstanding = 0, drop = 0. Outputs: `imem_req` = 0, `if_valid` = 0, `if_inst` = NOP, `if_pc` = 0.
- Redirect: `redir` = `br_ctrl` | `ret_ctrl`. `br_ctrl` wins if both are asserted: target = `br_addr`, else `ret_pc`. On redirect: `fetch_pc` ← target; FIFO cleared; drop ← outstanding count after this edge, i.e. outstanding + gnt − rvalid; this cycle's rvalid is discarded.
- Issue: `imem_req` = !`redir` & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding < FETCH_DEPTH). `imem_addr` = `fetch_pc`. On req & gnt: `fetch_pc` += 4 (wraps mod 2^32); outstanding += 1. `imem_req` may drop without a grant only on a redirect cycle; the memory must tolerate request withdrawal.
- Return: on rvalid, outstanding −= 1. If drop > 0, drop −= 1 and the data is discarded. Otherwise {pc, inst} is pushed. PC tags come from a small in-order tag queue (MAX_OUTSTANDING entries) written on each grant. The credit rule above guarantees the FIFO never overflows.
- Consume: head popped when `if_valid` & !`pc_stall`, or when `if_valid` & `if_flush` (flush also pops while stalled). Push and pop in the same cycle are legal at any occupancy.
- Empty FIFO: `if_valid` = 0. Full FIFO: `imem_req` = 0 via credit.
- A redirect overrides `if_flush` and consume in the same cycle.

## Timing
- Outputs are driven from FIFO head registers; no combinational path from `imem_rdata` to `if_inst`.
- Response pushed at the rvalid edge is visible on `if_valid` the next cycle.
- 1-cycle memory (gnt same cycle, rvalid next cycle): redirect at cycle N → `imem_req`/target addr at N+1 → rvalid N+2 → `if_valid` at N+3.
- Steady state with `pc_stall` = 0 and MAX_OUTSTANDING ≥ 2: one instruction per cycle.
- `rstn` asserted mid-operation clears everything immediately. In-flight responses arriving after reset release are the environment's responsibility; the memory is reset together with the core.

## Structure
- Package `if_pkg`: NOP constant 32'h0000_0013; `fetch_entry_t` = {pc[31:0], inst[31:0]}; `if_redirect_t` enum {NONE, BRANCH, RETURN}.
- Sub-module `fetch_fifo` (parametrised DEPTH/WIDTH, synchronous clear, push/pop/count). Instantiated twice: data FIFO (FETCH_DEPTH) and PC tag queue (MAX_OUTSTANDING).
- Counters `outstanding` and `drop` are $clog2(MAX_OUTSTANDING+1) bits wide.

## Test plan
- Reset release, 1-cycle memory, no stall → addresses 0x0, 0x4, 0x8…; `if_valid` from cycle 3; `if_pc` increments by 4 each cycle.
- `pc_stall` held 10 cycles → `if_pc`/`if_inst` frozen; `imem_req` stops after 4 queued entries; no loss on release.
- `br_ctrl` with `br_addr` = 0x100 while 2 requests are in flight → both responses discarded; next `if_pc` = 0x100, `if_valid` 3 cycles later.
- `br_ctrl` and `ret_ctrl` in the same cycle (`br_addr` 0x200, `ret_pc` 0x300) → fetch resumes at 0x200.
- `if_flush` pulse during stall with head PC 0x10 → 0x10 dropped; next head 0x14.
- Random gnt/rvalid delays (0–5 cycles) with random redirects → delivered PCs match the reference sequence; no FIFO overflow; outstanding never exceeds 2.
